// File: rtl/dig_pkg.sv
// rtl/dig_pkg.sv - shared constants for the 8-digit scan controller
package dig_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/dig_scan_ctrl_hex7seg.sv
// rtl/dig_scan_ctrl_hex7seg.sv - combinational nibble to active-low 7-segment glyph
module hex7seg
  import dig_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = GLYPH_0;
    case (nibble)
      4'h0: seg7 = GLYPH_0;
      4'h1: seg7 = GLYPH_1;
      4'h2: seg7 = GLYPH_2;
      4'h3: seg7 = GLYPH_3;
      4'h4: seg7 = GLYPH_4;
      4'h5: seg7 = GLYPH_5;
      4'h6: seg7 = GLYPH_6;
      4'h7: seg7 = GLYPH_7;
      4'h8: seg7 = GLYPH_8;
      4'h9: seg7 = GLYPH_9;
      4'hA: seg7 = GLYPH_A;
      4'hB: seg7 = GLYPH_B;
      4'hC: seg7 = GLYPH_C;
      4'hD: seg7 = GLYPH_D;
      4'hE: seg7 = GLYPH_E;
      4'hF: seg7 = GLYPH_F;
      default: seg7 = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/dig_scan_ctrl.sv
// rtl/dig_scan_ctrl.sv - tear-free time-multiplexed 8-digit 7-segment scan controller
module dig_scan_ctrl
  import dig_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [2:0]       idx;
  logic [31:0]      shadow;
  logic [31:0]      disp;
  logic             pending;

  logic             digit_wrap;
  logic             frame_edge;
  logic [4:0]       nib_pos;
  logic [3:0]       nibble;
  logic [31:0]      upper_bits;
  logic             lz_blank;
  logic             visible;
  logic [6:0]       glyph;
  logic [7:0]       an_next;
  logic [7:0]       seg_next;

  assign digit_wrap = (div_cnt == DIV_LAST);
  assign frame_edge = digit_wrap && (idx == IDX_LAST);

  assign nib_pos    = {idx, 2'b00};
  assign nibble     = disp[nib_pos +: 4];
  assign upper_bits = disp >> nib_pos;

  // Digit 0 always shows, so a zero word still displays a single "0"
  assign lz_blank   = blank_lz && (idx != 3'd0) && (upper_bits == 32'd0);
  assign visible    = digit_en[idx] && !lz_blank;

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg7   (glyph)
  );

  always_comb begin
    an_next  = SEG_OFF;
    seg_next = SEG_OFF;
    if (visible) begin
      an_next  = ~(8'b1 << idx);
      seg_next = {~dp_in[idx], glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= 3'd0;
      shadow     <= 32'd0;
      disp       <= 32'd0;
      pending    <= 1'b0;
      an         <= SEG_OFF;
      seg        <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= digit_wrap ? '0 : div_cnt + CNT_W'(1);
      if (digit_wrap) begin
        idx <= idx + 3'd1;
      end
      frame_tick <= frame_edge;

      // Commit takes the pre-edge shadow; a simultaneous write re-arms pending
      if (frame_edge && pending) begin
        disp <= shadow;
      end
      if (wr_en) begin
        shadow  <= wr_data;
        pending <= 1'b1;
      end else if (frame_edge && pending) begin
        pending <= 1'b0;
      end

      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
